mux_scan_sel: RTL and testbench

- Parametrised N-channel, WIDTH-bit registered multiplexer.
- Successor to the 2:1 single-bit gate-level mux.
- Adds a manual select mode, an auto-scan mode driven by an internal tick divider, and a hold/freeze control.
- Feeds board-level displays (LEDR/HEX) from several switch or data sources.

---
 rtl/mux_scan_sel_pkg.sv | 19 +
 rtl/mux_scan_sel_tick_divider.sv | 40 ++++
 rtl/mux_scan_sel.sv | 119 +++++++++++
 tb/tb_mux_scan_sel.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mux_scan_sel_pkg.sv
// Shared types and helpers for the scanning channel multiplexer.
package mux_scan_pkg;

  // Operating modes, decoded from hold/mode with hold taking priority.
  typedef enum logic [1:0] {
    S_MANUAL = 2'd0,
    S_SCAN   = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  // Step one channel up or down, wrapping at either end of 0..n-1.
  function automatic int next_channel(input int cur, input int n, input logic down);
    if (down) begin
      return (cur == 0) ? (n - 1) : (cur - 1);
    end
    return (cur == n - 1) ? 0 : (cur + 1);
  endfunction

endpackage

// File: rtl/mux_scan_sel_tick_divider.sv
// Scan-step divider: counts 0..DIV-1 while enabled, pulses tick on the last
// count, freezes when disabled and clears synchronously on clr.
module tick_divider #(
  parameter int DIV = 50000000
) (
  input  logic clock,
  input  logic resetn,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(DIV + 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Tick only while counting, so a frozen count at DIV-1 fires on resume.
  assign tick = en && (count_q == CW'(DIV - 1));

  // Next count: clear wins, otherwise advance and wrap when enabled.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = tick ? '0 : (count_q + CW'(1));
    end
  end

  // Count register with asynchronous reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mux_scan_sel.sv
// Registered N-channel WIDTH-bit multiplexer with manual select, auto-scan
// driven by an internal divider, and a hold/freeze control.
// Optional macro MUX_SCAN_DIR_EN adds a dir input that lets scan count down.
module mux_scan_sel
  import mux_scan_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int N     = 4,
  parameter int DIV   = 50000000,
  parameter int SEL_W = $clog2(N)
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic [N*WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0]   sel,
  input  logic               mode,
`ifdef MUX_SCAN_DIR_EN
  input  logic               dir,
`endif
  input  logic               hold,
  output logic [WIDTH-1:0]   data_out,
  output logic [SEL_W-1:0]   cur_sel,
  output logic               chg
);

  state_t             state;
  logic               div_en;
  logic               div_clr;
  logic               tick;
  logic               scan_down;
  logic [SEL_W-1:0]   next_sel;
  logic [SEL_W-1:0]   cur_sel_q;
  logic [SEL_W-1:0]   cur_sel_d;
  logic [WIDTH-1:0]   data_out_q;
  logic [WIDTH-1:0]   data_out_d;
  logic               chg_q;
  logic               chg_d;

  // Mode decode acts on the current cycle so hold can veto a same-cycle tick.
  always_comb begin
    state = S_MANUAL;
    if (hold) begin
      state = S_HOLD;
    end else if (mode) begin
      state = S_SCAN;
    end
  end

  // Divider control: run in scan, freeze in hold, park at zero in manual.
  always_comb begin
    div_en  = (state == S_SCAN);
    div_clr = (state == S_MANUAL);
  end

  tick_divider #(
    .DIV (DIV)
  ) u_div (
    .clock  (clock),
    .resetn (resetn),
    .en     (div_en),
    .clr    (div_clr),
    .tick   (tick)
  );

`ifdef MUX_SCAN_DIR_EN
  // Direction only matters on a tick, so it is qualified by tick here.
  assign scan_down = tick & dir;
`else
  assign scan_down = 1'b0;
`endif

  // Channel choice for the coming edge in each mode.
  always_comb begin
    next_sel = cur_sel_q;
    case (state)
      S_MANUAL: begin
        if (int'(sel) < N) begin
          next_sel = sel;
        end
      end
      S_SCAN: begin
        if (tick) begin
          next_sel = SEL_W'(next_channel(int'(cur_sel_q), N, scan_down));
        end
      end
      default: next_sel = cur_sel_q;
    endcase
  end

  // Register next-state: data always follows next_sel so it tracks live input.
  always_comb begin
    cur_sel_d  = cur_sel_q;
    data_out_d = data_out_q;
    chg_d      = 1'b0;
    if (state != S_HOLD) begin
      cur_sel_d  = next_sel;
      data_out_d = data_in[int'(next_sel)*WIDTH +: WIDTH];
      chg_d      = (next_sel != cur_sel_q);
    end
  end

  // Output registers with asynchronous reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cur_sel_q  <= '0;
      data_out_q <= '0;
      chg_q      <= 1'b0;
    end else begin
      cur_sel_q  <= cur_sel_d;
      data_out_q <= data_out_d;
      chg_q      <= chg_d;
    end
  end

  assign data_out = data_out_q;
  assign cur_sel  = cur_sel_q;
  assign chg      = chg_q;

endmodule

// File: tb/tb_mux_scan_sel.sv
// Directed bench for mux_scan_sel with N=4, WIDTH=4, DIV=3.
module tb_mux_scan_sel;

  localparam int WIDTH = 4;
  localparam int N     = 4;
  localparam int DIV   = 3;
  localparam int SEL_W = 2;

  logic               clock;
  logic               resetn;
  logic [N*WIDTH-1:0] data_in;
  logic [SEL_W-1:0]   sel;
  logic               mode;
  logic               dir;
  logic               hold;
  logic [WIDTH-1:0]   data_out;
  logic [SEL_W-1:0]   cur_sel;
  logic               chg;

  int total;
  int bad;

  mux_scan_sel #(
    .WIDTH (WIDTH),
    .N     (N),
    .DIV   (DIV)
  ) dut (
    .clock    (clock),
    .resetn   (resetn),
    .data_in  (data_in),
    .sel      (sel),
    .mode     (mode),
`ifdef MUX_SCAN_DIR_EN
    .dir      (dir),
`endif
    .hold     (hold),
    .data_out (data_out),
    .cur_sel  (cur_sel),
    .chg      (chg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle past it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk3(input string tag, input logic [3:0] d, input logic [1:0] s, input logic c);
    chk({tag, ".data_out"}, 32'(data_out), 32'(d));
    chk({tag, ".cur_sel"},  32'(cur_sel),  32'(s));
    chk({tag, ".chg"},      32'(chg),      32'(c));
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    resetn  = 1'b0;
    data_in = {4'hD, 4'hC, 4'hB, 4'hA};
    sel     = 2'd0;
    mode    = 1'b0;
    dir     = 1'b0;
    hold    = 1'b0;

    step();
    step();
    chk3("rst", 4'h0, 2'd0, 1'b0);

    resetn = 1'b1;
    step();
    chk3("idle", 4'hA, 2'd0, 1'b0);

    // Manual select
    sel = 2'd2;
    step();
    chk3("man_sel2", 4'hC, 2'd2, 1'b1);
    step();
    chk3("man_hold_sel", 4'hC, 2'd2, 1'b0);

    // Scan from channel 2, wrapping through 3 to 0
    mode = 1'b1;
    step();
    chk3("scan_e1", 4'hC, 2'd2, 1'b0);
    step();
    chk3("scan_e2", 4'hC, 2'd2, 1'b0);
    step();
    chk3("scan_to3", 4'hD, 2'd3, 1'b1);
    step();
    chk3("scan_e4", 4'hD, 2'd3, 1'b0);
    step();
    step();
    chk3("scan_wrap0", 4'hA, 2'd0, 1'b1);

    // Hold asserted on the tick cycle
    step();
    step();
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk3($sformatf("held%0d", i), 4'hA, 2'd0, 1'b0);
    end
    hold = 1'b0;
    step();
    chk3("hold_release", 4'hB, 2'd1, 1'b1);

    // Live data on the selected channel
    mode = 1'b0;
    sel  = 2'd1;
    step();
    chk3("live_pre", 4'hB, 2'd1, 1'b0);
    data_in[1*WIDTH +: WIDTH] = 4'h7;
    step();
    chk3("live_data", 4'h7, 2'd1, 1'b0);

    // Asynchronous reset in the middle of a scan
    sel = 2'd3;
    step();
    chk3("pre_rst", 4'hD, 2'd3, 1'b1);
    mode = 1'b1;
    step();
    #2;
    resetn = 1'b0;
    #1;
    chk3("async_rst", 4'h0, 2'd0, 1'b0);
    step();
    resetn = 1'b1;
    data_in = {4'hD, 4'hC, 4'hB, 4'hA};
    step();
    chk3("post_rst_e1", 4'hA, 2'd0, 1'b0);
    step();
    chk3("post_rst_e2", 4'hA, 2'd0, 1'b0);
    step();
    chk3("post_rst_e3", 4'hB, 2'd1, 1'b1);

`ifdef MUX_SCAN_DIR_EN
    // Downward scan from channel 0
    mode = 1'b0;
    sel  = 2'd0;
    step();
    chk3("dir_start", 4'hA, 2'd0, 1'b1);
    mode = 1'b1;
    dir  = 1'b1;
    step();
    step();
    step();
    chk3("dir_3", 4'hD, 2'd3, 1'b1);
    step();
    step();
    step();
    chk3("dir_2", 4'hC, 2'd2, 1'b1);
    step();
    step();
    step();
    chk3("dir_1", 4'hB, 2'd1, 1'b1);
    step();
    step();
    step();
    chk3("dir_0", 4'hA, 2'd0, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
